updi_tx_serializer: RTL and testbench
=====================================

Name: updi_tx_serializer

Overview:
Downstream stage of the UPDI command generator. Accepts 12-bit pre-framed UART characters over a valid/ready handshake and shifts them onto the single-wire UPDI line at a fixed baud divider. Inserts guard (idle-high) bits between characters. Releases the line drive when a transaction ends, so the receive path can take over.

Parameters:
CLK_DIV, 16, i_clk cycles per UPDI bit; legal minimum 2.
GUARD_BITS, 2, idle-high bit times inserted after every frame's stop bits; legal range 0..15.

Ports:
i_clk  in  1  clock
i_rstn  in  1  synchronous active-low reset
i_frame  in  12  frame: [11]=start(0), [10:3]=data d7..d0 ([3]=d0), [2]=even parity, [1:0]=stop(11)
i_valid  in  1  i_frame valid
o_ready  out  1  block can accept a frame this cycle
i_trans_en  in  1  sampled with an accepted frame; 1 = last frame of the transaction
o_tx  out  1  UPDI line level (idle high)
o_tx_oe  out  1  line drive enable
o_busy  out  1  frame or guard time in progress
o_done  out  1  one-cycle pulse when the line is released after the last frame
o_frame_err  out  1  one-cycle pulse on a rejected frame (feature only; else constant 0)

Behaviour:
- Reset (i_rstn sampled 0 at posedge): state IDLE, o_tx=1, o_tx_oe=0, o_ready=0, o_busy=0, o_done=0, o_frame_err=0; all counters cleared.
- Reset mid-frame aborts immediately and returns the outputs to their reset values on the next edge. No partial completion and no o_done.
- All outputs are registered.
- o_ready=1 only in IDLE and not in the cycle of the reset release. It reads 1 from the second cycle after reset deasserts.
- A frame is accepted on a posedge where i_valid && o_ready. The block latches i_frame and i_trans_en, clears o_ready and sets o_busy and o_tx_oe.
- i_valid while o_ready=0 is ignored. The upstream holds its data; no buffering.
- Bit order on o_tx: start=i_frame[11], then i_frame[3], [4] ... [10] (d0 first), then parity [2], then stop [1], stop [0]. 12 bit times total.
- The bit is driven exactly as latched; the block does not substitute start, stop or parity values.
- Latency: the start bit appears on o_tx the cycle after acceptance. Each bit is held CLK_DIV cycles.
- States:
  - IDLE: wait for an accepted frame -> SHIFT.
  - SHIFT: bit counter 0..11, baud counter 0..CLK_DIV-1. At baud terminal count the bit counter increments; after bit 11 -> GUARD, or -> IDLE if GUARD_BITS=0.
  - GUARD: o_tx=1 for GUARD_BITS*CLK_DIV cycles, then IDLE.
- Leaving to IDLE:
  - If latched trans_en=1: o_tx_oe goes 0 on the IDLE entry edge, o_done pulses 1 cycle in that same cycle, o_busy goes 0.
  - If latched trans_en=0: o_tx_oe stays 1 and the line is held high while idle.
- o_ready re-asserts on the IDLE entry cycle. Back-to-back frames are spaced by exactly (12+GUARD_BITS)*CLK_DIV+1 cycles (one handshake cycle).
- o_tx=1 whenever o_tx_oe=0.
- Counter widths: the baud counter is $clog2(CLK_DIV) bits and the bit counter is 4 bits. Wrap occurs only at terminal count, never modulo overflow.

Optional Feature:
UPDI_TX_FRAME_CHECK_EN
- Defined:
  - At acceptance the block checks start==0, stop==2'b11 and parity==^i_frame[10:3].
  - On any mismatch the frame is dropped. The block stays in IDLE with o_ready=1 and o_tx/o_tx_oe unchanged.
  - o_frame_err pulses 1 cycle (the cycle after acceptance).
  - The dropped frame's trans_en is discarded.
- Undefined: no check is made, frames are sent verbatim, and o_frame_err is tied 0.

Test Plan:
- CLK_DIV=4, GUARD_BITS=2, frame {0,8'h55,0,11} (0x2AB) with trans_en=0 -> o_tx sequence per 4 cycles: 0,1,0,1,0,1,0,1,0,0,1,1, then 8 cycles high. o_ready returns 57 cycles after acceptance; o_tx_oe stays 1; o_done never pulses.
- Frames 0x55 (trans_en=0) then 0x64 (trans_en=1) back-to-back -> second start bit begins exactly 57 cycles after the first. After the second guard, o_tx_oe=0 and o_done pulses once.
- i_valid held high with changing i_frame during SHIFT -> no extra accept. Only the frame present at the handshake edge is transmitted.
- Reset asserted at bit 5 of a frame -> next cycle o_tx=1, o_tx_oe=0, o_busy=0, o_done=0. o_ready is 1 two cycles after release.
- GUARD_BITS=0, CLK_DIV=2 -> a frame occupies 24 cycles; o_ready asserts on cycle 25 after acceptance.
- UPDI_TX_FRAME_CHECK_EN, frame data 0x01 with parity 0 -> o_frame_err pulse, o_tx stays 1, o_busy stays 0. The following valid frame 0x01 with parity 1 is transmitted normally.

Source files
------------

// File: rtl/updi_tx_serializer.sv
// updi_tx_serializer: shifts pre-framed 12-bit UPDI characters onto the line with guard time and drive release.
// Define UPDI_TX_FRAME_CHECK_EN to reject frames with a bad start, stop or parity at acceptance.
module updi_tx_serializer #(
  parameter int CLK_DIV    = 16,
  parameter int GUARD_BITS = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [11:0] i_frame,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_trans_en,
  output logic        o_tx,
  output logic        o_tx_oe,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_frame_err
);
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef UPDI_TX_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;
  state_t state;
  logic [BW-1:0] baud;
  logic [3:0] bits;
  logic [10:0] sr;
  logic last, init, accept, bad, baud_tc, to_idle;
  assign accept = i_valid && o_ready;
  assign bad = CHK && (i_frame[11] || i_frame[1:0] != 2'b11 || i_frame[2] != ^i_frame[10:3]);
  assign baud_tc = baud == BW'(CLK_DIV - 1);
  assign to_idle = baud_tc && ((state == SHIFT && bits == 4'd11 && GUARD_BITS == 0) ||
                               (state == GUARD && bits == 4'(GUARD_BITS - 1)));
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state       <= IDLE;
      baud        <= '0;
      bits        <= '0;
      sr          <= '0;
      last        <= 1'b0;
      init        <= 1'b0;
      o_tx        <= 1'b1;
      o_tx_oe     <= 1'b0;
      o_ready     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      init        <= 1'b1;
      o_done      <= 1'b0;
      o_frame_err <= 1'b0;
      case (state)
        IDLE: begin
          o_ready <= init;
          if (accept && bad) begin
            o_frame_err <= 1'b1;
          end else if (accept) begin
            state   <= SHIFT;
            // remaining bits in line order: d0..d7, parity, stop, stop
            sr      <= {i_frame[3], i_frame[4], i_frame[5], i_frame[6], i_frame[7],
                        i_frame[8], i_frame[9], i_frame[10], i_frame[2:0]};
            last    <= i_trans_en;
            o_tx    <= i_frame[11];
            o_tx_oe <= 1'b1;
            o_busy  <= 1'b1;
            o_ready <= 1'b0;
            baud    <= '0;
            bits    <= '0;
          end
        end
        SHIFT: begin
          baud <= baud_tc ? '0 : baud + 1'b1;
          if (baud_tc && bits == 4'd11) begin
            bits  <= '0;
            state <= GUARD;
            o_tx  <= 1'b1;
          end else if (baud_tc) begin
            bits <= bits + 4'd1;
            o_tx <= sr[10];
            sr   <= {sr[9:0], 1'b1};
          end
        end
        default: begin
          baud <= baud_tc ? '0 : baud + 1'b1;
          if (baud_tc) bits <= bits + 4'd1;
        end
      endcase
      if (to_idle) begin
        state   <= IDLE;
        bits    <= '0;
        o_ready <= 1'b1;
        o_busy  <= 1'b0;
        o_tx    <= 1'b1;
        o_tx_oe <= !last;
        o_done  <= last;
      end
    end
  end
endmodule

// File: tb/tb_updi_tx_serializer.sv
// tb_updi_tx_serializer: vector table plus scoreboard of expected line levels for the UPDI serializer.
module tb_updi_tx_serializer;
  localparam int D = 4, G = 2, N = (12 + G) * D;
  logic clk = 1'b0, rstn = 1'b0;
  logic [11:0] frame = '0, frame1 = '0;
  logic valid = 1'b0, te = 1'b0, valid1 = 1'b0, te1 = 1'b0;
  logic tx, oe, ready, busy, done, ferr;
  logic tx1, oe1, ready1, busy1, done1, ferr1;
  int compared = 0, mismatched = 0, cyc = 0, done_cnt = 0, err_cnt = 0, exp_done = 0;
  bit q[$];
  typedef struct {logic [11:0] f; logic te; bit hold;} vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ferr) err_cnt++;
  end

  updi_tx_serializer #(.CLK_DIV(D), .GUARD_BITS(G)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_frame(frame), .i_valid(valid), .o_ready(ready),
    .i_trans_en(te), .o_tx(tx), .o_tx_oe(oe), .o_busy(busy), .o_done(done), .o_frame_err(ferr));

  updi_tx_serializer #(.CLK_DIV(2), .GUARD_BITS(0)) dut_g0 (
    .i_clk(clk), .i_rstn(rstn), .i_frame(frame1), .i_valid(valid1), .o_ready(ready1),
    .i_trans_en(te1), .o_tx(tx1), .o_tx_oe(oe1), .o_busy(busy1), .o_done(done1), .o_frame_err(ferr1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic bit bit_at(input logic [11:0] f, input int k);
    if (k == 0) return f[11];
    if (k <= 8) return f[k + 2];
    return f[11 - k];
  endfunction

  task automatic send(input logic [11:0] f, input logic e, input bit hold, output int acc);
    int n = 0;
    bit ok = 1'b1;
    frame = f;
    te = e;
    valid = 1'b1;
    while (!ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", 0, 1);
      valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (e) exp_done++;
    for (int k = 0; k < 12; k++) for (int c = 0; c < D; c++) q.push_back(bit_at(f, k));
    for (int c = 0; c < G * D; c++) q.push_back(1'b1);
    @(negedge clk);
    if (hold) frame = ~f;
    else valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("tx_bit", tx, q.pop_front());
      if (!(busy && oe && !ready)) ok = 1'b0;
      @(negedge clk);
    end
    valid = 1'b0;
    chk("busy_oe_during_frame", ok, 1);
    chk("ready_idle", ready, 1);
    chk("busy_idle", busy, 0);
    chk("oe_idle", oe, !e);
    chk("done_idle", done, e);
    chk("tx_idle", tx, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, prev, n;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_oe", oe, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ferr", ferr, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_release_cycle", ready, 0);
    @(negedge clk);
    chk("ready_second_cycle", ready, 1);

    vecs.push_back('{12'h2AB, 1'b0, 1'b0});
    vecs.push_back('{12'h327, 1'b1, 1'b0});
    vecs.push_back('{12'h52B, 1'b0, 1'b1});
    vecs.push_back('{12'h003, 1'b0, 1'b0});
`ifndef UPDI_TX_FRAME_CHECK_EN
    vecs.push_back('{12'h00B, 1'b0, 1'b0});
    vecs.push_back('{12'h800, 1'b1, 1'b0});
`endif
    vecs.push_back('{12'h7FB, 1'b1, 1'b0});
    prev = 0;
    foreach (vecs[i]) begin
      send(vecs[i].f, vecs[i].te, vecs[i].hold, acc);
      if (i == 1) chk("b2b_spacing", acc - prev, N + 1);
      prev = acc;
    end
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("oe_released", oe, 0);
    chk("tx_released_high", tx, 1);

`ifdef UPDI_TX_FRAME_CHECK_EN
    frame = 12'h00B;
    te = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("ferr_pulse", ferr, 1);
    chk("ferr_ready", ready, 1);
    chk("ferr_busy", busy, 0);
    chk("ferr_tx", tx, 1);
    chk("ferr_oe", oe, 0);
    @(negedge clk);
    chk("ferr_one_cycle", ferr, 0);
    chk("ferr_still_idle", busy, 0);
    send(12'h00F, 1'b1, 1'b0, acc);
    @(negedge clk);
`endif

    frame = 12'h2AB;
    te = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (5 * D) @(negedge clk);
    chk("midframe_busy", busy, 1);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx, 1);
    chk("abort_oe", oe, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", ready, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_ready_release", ready, 0);
    @(negedge clk);
    chk("abort_ready_second", ready, 1);

    frame1 = 12'h327;
    te1 = 1'b1;
    valid1 = 1'b1;
    @(negedge clk);
    valid1 = 1'b0;
    n = 0;
    while (!ready1 && n < 100) begin
      if (n < 24) chk("g0_tx_bit", tx1, bit_at(12'h327, n / 2));
      n++;
      @(negedge clk);
    end
    chk("g0_ready_latency", n, 24);
    chk("g0_done", done1, 1);
    chk("g0_oe", oe1, 0);
    chk("g0_ferr", ferr1, 0);

    chk("done_pulses", done_cnt, exp_done);
`ifdef UPDI_TX_FRAME_CHECK_EN
    chk("ferr_pulses", err_cnt, 1);
`else
    chk("ferr_pulses", err_cnt, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
